bitmap_scan_encoder: RTL

Sequential, parametrised bitmap-to-number encoder. It accepts a BITW-bit bitmap over a valid/ready handshake, then emits the index of every set bit, one per transfer, on a valid/ready output stream. Scan order is fixed at elaboration time: highest index first or lowest first. It sits between event/request bitmaps (interrupt pending, free-slot maps, channel-active maps) and logic that consumes one index at a time.

---
 rtl/bitmap_scan_if.sv | 28 ++
 rtl/bitmap_scan_encoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bitmap_scan_if.sv
// Handshake bundle for the bitmap scan encoder:
// a bitmap input stream and an index output stream.
interface bitmap_scan_if #(
   parameter int NUMW = 4,
   parameter int BITW = 2**NUMW
);
   logic            in_vld;
   logic            in_rdy;
   logic [BITW-1:0] in_bitmap;
   logic            out_vld;
   logic            out_rdy;
   logic [NUMW-1:0] out_number;
   logic            out_last;
   logic [NUMW:0]   out_cnt;
   logic            nul_pls;

   modport master (
      output in_vld, in_bitmap, out_rdy,
      input  in_rdy, out_vld, out_number,
      input  out_last, out_cnt, nul_pls
   );

   modport slave (
      input  in_vld, in_bitmap, out_rdy,
      output in_rdy, out_vld, out_number,
      output out_last, out_cnt, nul_pls
   );
endinterface

// File: rtl/bitmap_scan_encoder.sv
// Accepts a bitmap and streams out the index of each set bit,
// highest-first or lowest-first depending on MSB_FIRST.
module bitmap_scan_encoder #(
   parameter int NUMW      = 4,
   parameter int BITW      = 2**NUMW,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic          clk,
   input logic          rst,
   input logic          ena,
   bitmap_scan_if.slave bus
);
   typedef enum logic {IDLE, SCAN} state_e;

   localparam logic [BITW-1:0] ONE = BITW'(1);

   state_e          state_q, state_d;
   logic [BITW-1:0] pend_q, pend_d;
   logic [NUMW-1:0] num_q, num_d;
   logic            last_q, last_d;
   logic [NUMW:0]   cnt_q, cnt_d;
   logic            nul_q, nul_d;
   logic            in_rdy_c, out_vld_c;
   logic            in_xfer, out_xfer;
   logic [BITW-1:0] rem;
   logic [NUMW:0]   in_pop;

   function automatic logic [NUMW-1:0] prio(
      input logic [BITW-1:0] v
   );
      logic [NUMW-1:0] r;
      r = '0;
      // Later matches overwrite earlier ones, so the walk
      // direction selects which end of the bitmap wins.
      if (MSB_FIRST) begin
         for (int i = 0; i < BITW; i++)
            if (v[i]) r = NUMW'(i);
      end else begin
         for (int i = BITW-1; i >= 0; i--)
            if (v[i]) r = NUMW'(i);
      end
      return r;
   endfunction

   function automatic logic [NUMW:0] popcnt(
      input logic [BITW-1:0] v
   );
      logic [NUMW:0] c;
      c = '0;
      for (int i = 0; i < BITW; i++)
         c = c + (NUMW+1)'(v[i]);
      return c;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_xfer && (|bus.in_bitmap)) state_d = SCAN;
         SCAN: if (out_xfer && last_q)          state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_rdy_c  = ena && (state_q == IDLE);
      out_vld_c = ena && (state_q == SCAN);
   end

   assign in_xfer  = bus.in_vld & in_rdy_c;
   assign out_xfer = out_vld_c & bus.out_rdy;
   assign in_pop   = popcnt(bus.in_bitmap);

   always_comb begin
      pend_d = pend_q;
      num_d  = num_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      nul_d  = 1'b0;
      rem    = pend_q & ~(ONE << num_q);
      if (in_xfer) begin
         if (|bus.in_bitmap) begin
            pend_d = bus.in_bitmap;
            cnt_d  = in_pop;
            num_d  = prio(bus.in_bitmap);
            last_d = (in_pop == (NUMW+1)'(1));
         end else begin
            nul_d = 1'b1;
         end
      end else if (out_xfer) begin
         if (last_q) begin
            pend_d = '0;
            num_d  = '0;
            last_d = 1'b0;
            cnt_d  = '0;
         end else begin
            pend_d = rem;
            cnt_d  = cnt_q - (NUMW+1)'(1);
            num_d  = prio(rem);
            last_d = (cnt_q == (NUMW+1)'(2));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         num_q  <= '0;
         last_q <= 1'b0;
         cnt_q  <= '0;
         nul_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         num_q  <= num_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
         nul_q  <= nul_d;
      end
   end

   assign bus.in_rdy     = in_rdy_c;
   assign bus.out_vld    = out_vld_c;
   assign bus.out_number = num_q;
   assign bus.out_last   = last_q;
   assign bus.out_cnt    = cnt_q;
   assign bus.nul_pls    = nul_q;
endmodule
